// File: rtl/quad_pkg.sv
// Shared definitions for the filtered quadrature decoder: resolution-mode
// encodings and the A/B transition classifier.
package quad_pkg;

    localparam logic [1:0] QUAD_MODE_X4     = 2'b00;
    localparam logic [1:0] QUAD_MODE_X2     = 2'b01;
    localparam logic [1:0] QUAD_MODE_X1     = 2'b10;
    localparam logic [1:0] QUAD_MODE_X4_ALT = 2'b11;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'b00,
        STEP_UP      = 2'b01,
        STEP_DOWN    = 2'b10,
        STEP_ILLEGAL = 2'b11
    } quad_step_e;

    // AB is {A,B}; the up sequence is 00 -> 10 -> 11 -> 01 -> 00.
    function automatic quad_step_e quad_step(input logic [1:0] prev_ab,
                                             input logic [1:0] next_ab);
        quad_step_e step;
        step = STEP_NONE;
        case ({prev_ab, next_ab})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = STEP_UP;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step = STEP_DOWN;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: step = STEP_ILLEGAL;
            default:                                step = STEP_NONE;
        endcase
        return step;
    endfunction

    // True when a legal transition is counted at the selected resolution.
    function automatic logic quad_mode_gate(input logic [1:0] mode,
                                            input logic [1:0] prev_ab,
                                            input logic [1:0] next_ab);
        logic a_changed;
        logic gate;
        a_changed = prev_ab[1] ^ next_ab[1];
        case (mode)
            QUAD_MODE_X2: gate = a_changed;
            QUAD_MODE_X1: gate = a_changed && !prev_ab[0] && !next_ab[0];
            default:      gate = 1'b1;
        endcase
        return gate;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder input: SYNC_STAGES-deep synchroniser followed by a glitch
// filter that accepts a new level after filter_len+1 consecutive samples.
module quad_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_BITS = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_async,
    input  logic [FILTER_BITS-1:0] i_filter_len,
    output logic                   o_filtered,
    output logic [FILTER_BITS-1:0] o_filter_cnt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILTER_BITS-1:0] r_cnt;
    logic                   r_filtered;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    // The >= compare lets a shortened filter_len take effect on the next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_filtered <= 1'b0;
        end else if (w_synced == r_filtered) begin
            r_cnt <= '0;
        end else if (r_cnt >= i_filter_len) begin
            r_filtered <= w_synced;
            r_cnt      <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_filtered   = r_filtered;
    assign o_filter_cnt = r_cnt;

endmodule

// File: rtl/quad_decoder_filtered.sv
// Quadrature decoder with filtered A/B/index inputs, x1/x2/x4 resolution,
// preset load, index capture/zeroing and sticky illegal-transition flag.
module quad_decoder_filtered
    import quad_pkg::*;
#(
    parameter int COUNT_BITS  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_BITS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         quad_a,
    input  logic                         quad_b,
    input  logic                         quad_i,
    input  logic [1:0]                   mode,
    input  logic [FILTER_BITS-1:0]       filter_len,
    input  logic                         load,
    input  logic signed [COUNT_BITS-1:0] load_value,
    input  logic                         index_zero_en,
    input  logic                         status_clear,
    output logic signed [COUNT_BITS-1:0] position,
    output logic                         direction,
    output logic                         count_strobe,
    output logic signed [COUNT_BITS-1:0] index_latch,
    output logic                         index_valid,
    output logic                         error
);

    localparam logic [COUNT_BITS-1:0] ONE = COUNT_BITS'(1);

    logic                   w_a;
    logic                   w_b;
    logic                   w_i;
    logic [FILTER_BITS-1:0] w_cnt_a;
    logic [FILTER_BITS-1:0] w_cnt_b;
    logic [FILTER_BITS-1:0] w_cnt_i;

    logic [1:0]             r_prev_ab;
    logic                   r_prev_i;
    logic [COUNT_BITS-1:0]  r_position;
    logic                   r_direction;
    logic                   r_strobe;
    logic [COUNT_BITS-1:0]  r_index_latch;
    logic                   r_index_valid;
    logic                   r_error;

    logic [1:0]             w_ab;
    quad_step_e             w_step;
    logic                   w_legal_move;
    logic                   w_count;
    logic                   w_up;
    logic                   w_index_rise;
    logic                   w_zero;

    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_BITS(FILTER_BITS)) u_filt_a (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .i_async      (quad_a),
        .i_filter_len (filter_len),
        .o_filtered   (w_a),
        .o_filter_cnt (w_cnt_a)
    );

    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_BITS(FILTER_BITS)) u_filt_b (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .i_async      (quad_b),
        .i_filter_len (filter_len),
        .o_filtered   (w_b),
        .o_filter_cnt (w_cnt_b)
    );

    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_BITS(FILTER_BITS)) u_filt_i (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .i_async      (quad_i),
        .i_filter_len (filter_len),
        .o_filtered   (w_i),
        .o_filter_cnt (w_cnt_i)
    );

    always_comb begin
        w_ab         = {w_a, w_b};
        w_step       = quad_step(r_prev_ab, w_ab);
        w_legal_move = (w_step == STEP_UP) || (w_step == STEP_DOWN);
        w_count      = w_legal_move && quad_mode_gate(mode, r_prev_ab, w_ab);
        w_up         = (w_step == STEP_UP);
        w_index_rise = w_i && !r_prev_i;
        w_zero       = w_index_rise && index_zero_en;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_ab <= 2'b00;
            r_prev_i  <= 1'b0;
        end else begin
            r_prev_ab <= w_ab;
            r_prev_i  <= w_i;
        end
    end

    // Load beats index zeroing beats a count; strobe/direction follow applied steps only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_position  <= '0;
            r_direction <= 1'b0;
            r_strobe    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (load) begin
                r_position <= load_value;
            end else if (w_zero) begin
                r_position <= '0;
            end else if (w_count) begin
                r_position  <= w_up ? (r_position + ONE) : (r_position - ONE);
                r_direction <= w_up;
                r_strobe    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_index_latch <= '0;
            r_index_valid <= 1'b0;
        end else if (w_index_rise) begin
            r_index_latch <= r_position;
            r_index_valid <= 1'b1;
        end else if (status_clear) begin
            r_index_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_error <= 1'b0;
        end else if (w_step == STEP_ILLEGAL) begin
            r_error <= 1'b1;
        end else if (status_clear) begin
            r_error <= 1'b0;
        end
    end

    assign position     = r_position;
    assign direction    = r_direction;
    assign count_strobe = r_strobe;
    assign index_latch  = r_index_latch;
    assign index_valid  = r_index_valid;
    assign error        = r_error;

endmodule

// File: tb/tb_quad_decoder_filtered.sv
// Directed plus randomised bench for quad_decoder_filtered against a
// position model built on Gray-code distance between encoder states.
module tb_quad_decoder_filtered;

    localparam int CB = 32;
    localparam int SS = 2;
    localparam int FB = 4;

    logic                 clk;
    logic                 reset_n;
    logic                 quad_a;
    logic                 quad_b;
    logic                 quad_i;
    logic [1:0]           mode;
    logic [FB-1:0]        filter_len;
    logic                 load;
    logic signed [CB-1:0] load_value;
    logic                 index_zero_en;
    logic                 status_clear;
    logic signed [CB-1:0] position;
    logic                 direction;
    logic                 count_strobe;
    logic signed [CB-1:0] index_latch;
    logic                 index_valid;
    logic                 error;

    quad_decoder_filtered #(.COUNT_BITS(CB), .SYNC_STAGES(SS), .FILTER_BITS(FB)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .quad_a        (quad_a),
        .quad_b        (quad_b),
        .quad_i        (quad_i),
        .mode          (mode),
        .filter_len    (filter_len),
        .load          (load),
        .load_value    (load_value),
        .index_zero_en (index_zero_en),
        .status_clear  (status_clear),
        .position      (position),
        .direction     (direction),
        .count_strobe  (count_strobe),
        .index_latch   (index_latch),
        .index_valid   (index_valid),
        .error         (error)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int strobe_seen = 0;

    // every cycle with count_strobe high counts as one applied step
    always @(negedge clk) if (count_strobe === 1'b1) strobe_seen++;

    // reference model state
    logic [CB-1:0] exp_pos;
    logic          exp_dir;
    logic [1:0]    exp_ab;
    logic          exp_err;
    logic          exp_valid;
    logic [CB-1:0] exp_latch;
    int            exp_strobes;

    function automatic int gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray_ab(input int idx);
        logic [1:0] seq [4];
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        return seq[idx % 4];
    endfunction

    // Gray distance 1 = up, 3 = down, 2 = illegal; mode picks which moves count.
    task automatic model_move(input logic [1:0] new_ab);
        int  d;
        logic counted;
        d = (gray_idx(new_ab) - gray_idx(exp_ab) + 4) % 4;
        if (d == 2) begin
            exp_err = 1'b1;
        end else if (d != 0) begin
            if (mode == 2'b01)      counted = (new_ab[1] != exp_ab[1]);
            else if (mode == 2'b10) counted = (new_ab[1] != exp_ab[1]) && !new_ab[0] && !exp_ab[0];
            else                    counted = 1'b1;
            if (counted) begin
                exp_pos = (d == 1) ? exp_pos + 1 : exp_pos - 1;
                exp_dir = (d == 1);
                exp_strobes++;
            end
        end
        exp_ab = new_ab;
    endtask

    task automatic model_reset();
        exp_pos = '0; exp_dir = 1'b0; exp_ab = 2'b00; exp_err = 1'b0;
        exp_valid = 1'b0; exp_latch = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [CB-1:0] got, input logic [CB-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".position"}, position, exp_pos);
        check({tag, ".direction"}, CB'(direction), CB'(exp_dir));
        check({tag, ".error"}, CB'(error), CB'(exp_err));
        check({tag, ".index_valid"}, CB'(index_valid), CB'(exp_valid));
        check({tag, ".index_latch"}, index_latch, exp_latch);
        check({tag, ".strobes"}, CB'(strobe_seen), CB'(exp_strobes));
    endtask

    // driver: apply a new AB level and hold it long enough to be decoded
    task automatic drive_ab(input logic [1:0] ab, input int hold);
        quad_a = ab[1];
        quad_b = ab[0];
        model_move(ab);
        tick(hold);
    endtask

    task automatic run_cycle(input bit up, input int hold);
        for (int k = 1; k <= 4; k++) drive_ab(gray_ab(up ? k : 4 - k), hold);
    endtask

    task automatic pulse_clear();
        status_clear = 1'b1;
        tick(1);
        status_clear = 1'b0;
        exp_err = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic do_load(input logic [CB-1:0] v);
        load_value = v;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        exp_pos = v;
    endtask

    initial begin
        reset_n = 1'b0; quad_a = 0; quad_b = 0; quad_i = 0; mode = 2'b00;
        filter_len = '0; load = 0; load_value = '0; index_zero_en = 0; status_clear = 0;
        exp_strobes = 0;
        model_reset();
        tick(3);
        check_all("reset");
        reset_n = 1'b1;
        tick(2);

        // x4 full cycle up then down
        run_cycle(1'b1, 10);
        check_all("x4_up");
        run_cycle(1'b0, 10);
        check_all("x4_down");

        // x2 and x1 resolutions
        mode = 2'b01;
        run_cycle(1'b1, 10);
        check_all("x2_up");
        mode = 2'b10;
        drive_ab(2'b10, 10);
        check("x1_first_step.position", position, exp_pos);
        drive_ab(2'b11, 10); drive_ab(2'b01, 10); drive_ab(2'b00, 10);
        check_all("x1_up");
        drive_ab(2'b01, 10); drive_ab(2'b11, 10); drive_ab(2'b10, 10);
        check("x1_rev_before_last.position", position, exp_pos);
        drive_ab(2'b00, 10);
        check_all("x1_down");
        mode = 2'b11;
        run_cycle(1'b1, 10);
        check_all("x4alt_up");

        // glitch filter: 3-cycle glitch rejected, 4-cycle pulse accepted
        mode = 2'b00;
        filter_len = 4'd3;
        quad_a = 1'b1; tick(3); quad_a = 1'b0; tick(15);
        check_all("glitch3");
        quad_a = 1'b1; tick(4); quad_a = 1'b0; tick(SS);
        check("latency_minus1.position", position, exp_pos);
        model_move(2'b10);
        tick(1);
        check("latency.position", position, exp_pos);
        check("latency.strobe", CB'(count_strobe), CB'(1));
        model_move(2'b00);
        tick(12);
        check_all("pulse4");
        filter_len = '0;

        // illegal transitions and status_clear precedence
        drive_ab(2'b11, 10);
        check_all("illegal_set");
        pulse_clear();
        tick(2);
        check_all("illegal_cleared");
        quad_a = 1'b0; quad_b = 1'b0;
        tick(SS + 1);
        status_clear = 1'b1;
        tick(1);
        status_clear = 1'b0;
        model_move(2'b00);
        tick(4);
        check_all("illegal_vs_clear");
        pulse_clear();

        // wrap and load precedence
        do_load(32'h7FFF_FFFF);
        drive_ab(2'b10, 10);
        check_all("wrap");
        quad_a = 1'b1; quad_b = 1'b1;
        tick(SS + 1);
        load_value = 32'h0000_1234;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        exp_pos = 32'h0000_1234;
        exp_ab = 2'b11;
        check("load_vs_step.strobe", CB'(count_strobe), CB'(0));
        tick(6);
        check_all("load_vs_step");

        // index capture with and without zeroing
        do_load(32'd25);
        index_zero_en = 1'b1;
        quad_i = 1'b1;
        tick(8);
        exp_latch = 32'd25; exp_valid = 1'b1; exp_pos = '0;
        check_all("index_zero");
        quad_i = 1'b0; index_zero_en = 1'b0;
        tick(6);
        drive_ab(2'b01, 10);
        quad_i = 1'b1;
        tick(8);
        exp_latch = exp_pos;
        check_all("index_capture");
        quad_i = 1'b0;
        tick(6);
        pulse_clear();
        tick(2);
        check_all("index_cleared");

        // randomised walk over modes and filter lengths
        for (int s = 0; s < 60; s++) begin
            int hold;
            mode = 2'($urandom_range(0, 3));
            filter_len = FB'($urandom_range(0, 3));
            hold = SS + int'(filter_len) + 4 + $urandom_range(0, 3);
            drive_ab(gray_ab(gray_idx(exp_ab) + ($urandom_range(0, 1) ? 1 : 3)), hold);
            check("rand.position", position, exp_pos);
            if (s % 10 == 9) check_all("rand");
        end

        // asynchronous reset in the middle of a transition
        mode = 2'b00; filter_len = '0;
        quad_a = ~exp_ab[1];
        tick(2);
        #2;
        reset_n = 1'b0;
        quad_a = 1'b0; quad_b = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        tick(3);
        #3;
        reset_n = 1'b1;
        tick(6);
        check_all("post_reset_idle");
        run_cycle(1'b1, 10);
        check_all("post_reset_up");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/quad_decoder_filtered.md
Name: quad_decoder_filtered

Overview:
Parametrised successor to the team's basic quadrature counter. Decodes one A/B/index encoder channel into a signed position with configurable synchroniser depth and runtime glitch filtering. Adds x1/x2/x4 resolution, preset load, index capture/zeroing, illegal-transition detection and direction/strobe outputs. Sits between the encoder input pins and the position/servo logic.

Parameters:
COUNT_BITS, 32, position and load/latch width (signed, two's complement)
SYNC_STAGES, 2, synchroniser flops per input; minimum 2
FILTER_BITS, 4, width of filter_len and of the per-input filter counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
quad_a  in  1  encoder A, asynchronous
quad_b  in  1  encoder B, asynchronous
quad_i  in  1  encoder index, asynchronous
mode  in  2  00=x4, 01=x2, 10=x1, 11=x4
filter_len  in  FILTER_BITS  glitch-filter length; 0 = no filtering
load  in  1  load position from load_value
load_value  in  COUNT_BITS  preset value
index_zero_en  in  1  zero position on index rising edge
status_clear  in  1  clear error and index_valid
position  out  COUNT_BITS  signed position
direction  out  1  direction of last count; 1=up
count_strobe  out  1  one-cycle pulse per count step
index_latch  out  COUNT_BITS  position captured at index edge
index_valid  out  1  sticky: an index edge was captured
error  out  1  sticky: illegal transition (A and B changed together)

Behaviour:
- Reset (reset_n low, asynchronous): all flops 0. position=0, direction=0, count_strobe=0, index_latch=0, index_valid=0, error=0. Synchroniser and filter state = 0, previous-AB state = 00.
- Sync: each input passes through SYNC_STAGES flops.
- Filter, per input: if synced==filtered, cnt<=0; else if cnt>=filter_len, filtered<=synced and cnt<=0; else cnt<=cnt+1. A change is accepted only after filter_len+1 consecutive differing cycles. Shorter pulses are discarded.
- Decode: prev_ab is a registered copy of filtered {A,B}. Up sequence is AB 00->10->11->01->00; down is the reverse. Both bits changing in one cycle sets error and produces no count.
- Mode gating:
  - x4: count every valid transition.
  - x2: count only transitions where A changes.
  - x1: count only A transitions with B==0 (00<->10).
  - mode is sampled each cycle; no pipeline flush is needed.
- Latency: a clean pin edge changes position SYNC_STAGES+filter_len+2 clocks after the first sampling edge.
- Position update priority per cycle:
  1. load: position<=load_value. A same-cycle count and index zeroing are dropped; index capture still occurs.
  2. index rising edge with index_zero_en: position<=0; the count is dropped.
  3. counted step: position<=position+/-1, wrapping modulo 2^COUNT_BITS (0x7FFFFFFF+1 -> 0x80000000).
- count_strobe: high for exactly the cycle after a step is applied. It is not asserted for load or zeroing. direction updates with each applied step only.
- Index: on a filtered quad_i rising edge, index_latch<=position (pre-update value of that cycle) and index_valid<=1.
- status_clear clears error and index_valid. If a set condition occurs in the same cycle, set wins.
- filter_len changes mid-filter: a cnt already >= the new filter_len accepts the change on the next cycle.
- Reset mid-operation: immediate return to reset state; the first post-reset count requires fresh filtered transitions from 00.

Decomposition:
- Package quad_pkg: mode encodings (QUAD_MODE_X4, QUAD_MODE_X2, QUAD_MODE_X1) and the up-sequence direction function (next_ab, prev_ab -> up/down/illegal/none).
- Sub-module quad_input_filter: synchroniser plus filter, parameters SYNC_STAGES and FILTER_BITS. Instantiated three times (A, B, I).

Test Plan:
- x4, filter_len=0, drive one full up cycle 00,10,11,01,00 at 10 clocks/state -> position 0->4, 4 strobes, direction=1. Reverse the cycle -> position back to 0, direction=0.
- Same cycle in x2 -> +2; in x1 -> +1, counted on the 00->10 step only. Reverse in x1 -> -1, on 10->00.
- filter_len=3, 3-cycle glitch on A -> no count. 4-cycle pulse -> accepted. Check that edge-to-count latency = SYNC_STAGES+5 clocks.
- Set A and B together 00->11 -> error=1, position unchanged. status_clear -> error=0. status_clear in the same cycle as a new illegal transition -> error stays 1.
- load_value=0x7FFFFFFF, load, then one up step -> position=0x80000000. load coincident with a step -> position=load_value, no strobe.
- Index edge at position 25 with index_zero_en=1 -> index_latch=25, index_valid=1, position=0. Assert reset_n low mid-count -> all outputs 0 asynchronously.
